ex_hilo: RTL and testbench
==========================

Name: ex_hilo

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the decoded bundle from the instruction-decode stage (aluOp, aluSel, reg1, reg2, wd, wreg) and produces the write-back triple.
- The write-back triple also drives the decoder's ex_* forwarding inputs.
- Owns the HI/LO registers and an iterative 32-cycle multiplier. Requests a pipeline stall while the multiplier is busy.

Parameters:
- MUL_STEPS, 32, shift-add iterations per multiply. Fixed at 32 for the 32-bit datapath; the parameter exists for bench speed-up only.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high (`RstEnable = 1'b1)
- aluOp_i  in  8  `AluOpBus`, from decode
- aluSel_i  in  3  `AluSelBus`, from decode
- reg1_i  in  32  operand 1 (register or immediate/shamt)
- reg2_i  in  32  operand 2 (register or immediate)
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable
- wd_o  out  5  latched destination address; goes to MEM and to decode ex_wd_i
- wreg_o  out  1  latched write enable; goes to MEM and to decode ex_wreg_i
- wdata_o  out  32  result; goes to MEM and to decode ex_wdata_i
- stallreq_o  out  1  high while a multiply occupies EX
- hi_o  out  32  current HI
- lo_o  out  32  current LO

Behaviour:
- Input latch: captures all *_i on the rising clk edge when stallreq_o=0. It holds its value while stallreq_o=1.
- wd_o, wreg_o and wdata_o are combinational from latch contents plus HI/LO. There is no extra latency, so forwarding to decode works in the same cycle.
- Reset (async, any time, including mid-multiply): latch cleared to NOP (aluOp `EXE_NOP_OP`, aluSel `EXE_RES_NOP`, wd 0, wreg 0, operands 0). Also: HI=LO=0, state IDLE, count 0, stallreq_o=0, wdata_o=0.
- Logic ops (aluSel `EXE_RES_LOGIC`):
  - OR: a|b
  - AND: a&b
  - XOR: a^b
  - NOR: ~(a|b)
  - a = reg1, b = reg2.
- Shift ops (aluSel `EXE_RES_SHIFT`), shift amount = reg1[4:0] only; upper bits ignored:
  - SLL: reg2<<amt
  - SRL: logical >>
  - SRA: arithmetic >>, sign from reg2[31]
  - amt=0 returns reg2.
- Move ops (aluSel `EXE_RES_MOVE`):
  - MFHI: wdata=HI.
  - MFLO: wdata=LO.
  - MTHI: HI<=reg1 at the edge ending the instruction's EX cycle. No GPR write; decode drives wreg=0.
  - MTLO: LO<=reg1 at the same edge, same rule.
  - MFHI directly after MTHI sees the new value, because HI is written before MFHI reaches EX.
- aluSel `EXE_RES_NOP` or any unknown aluSel/aluOp combination: wdata_o=0, wd_o/wreg_o still pass through from the latch.
- Multiply (aluOp `EXE_MULT_OP` signed, `EXE_MULTU_OP` unsigned; aluSel `EXE_RES_NOP`; wreg=0). FSM states IDLE, BUSY, DONE:
  - IDLE with MULT/MULTU in latch: stallreq_o=1. Next edge: load operands (magnitudes if signed), clear accumulator, count=0, go BUSY.
  - BUSY: stallreq_o=1. One shift-add step per cycle, count+1. On the edge where count==MUL_STEPS-1: {HI,LO} <= product, go DONE. Signed product is negated when reg1[31]^reg2[31].
  - DONE: stallreq_o=0. The latch takes the next instruction on this edge; go IDLE.
  - Total stall 33 cycles (1 IDLE + 32 BUSY); MULT leaves EX 34 cycles after entry.
  - Back-to-back MULT re-enters BUSY from IDLE normally.
  - Latch operands stay stable during BUSY because the latch is frozen.
- Signed edge case: 0x80000000 × 0x80000000 yields HI=0x40000000, LO=0. The magnitude path is 33-bit safe.
- HI/LO write priority: multiply completion and MTHI/MTLO cannot coincide, because the latch is frozen during BUSY. No arbitration is needed.

Decomposition:
- Add to defines.v:
  - `EXE_RES_MOVE` 3'b011
  - `EXE_MFHI_OP`, `EXE_MFLO_OP`, `EXE_MTHI_OP`, `EXE_MTLO_OP`, `EXE_MULT_OP`, `EXE_MULTU_OP` (8-bit, unique vs existing ops)
  - FSM state encodings for IDLE, BUSY, DONE
- Sub-module mul_iter: start/busy/done handshake, signed flag, two 32-bit operands in, 64-bit product out. Owns the counter and accumulator.
- ex_hilo owns the latch, result mux and HI/LO.

Test Plan:
- Logic: OR reg1=0x0F0F0000, reg2=0x0000FFFF -> wdata_o=0x0F0FFFFF, wd_o/wreg_o mirror inputs the cycle after capture. NOR 0, 0 -> 0xFFFFFFFF.
- Shifts: SRA reg1=0x00000024 (amt 4), reg2=0x80000000 -> 0xF8000000. SRL same -> 0x08000000. SLL amt 0 -> reg2 unchanged.
- Signed multiply: MULT 0xFFFFFFFE × 3 -> stallreq_o high exactly 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA. Following MFLO -> wdata_o=0xFFFFFFFA.
- Unsigned multiply: MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Back-to-back MULT 0x80000000² -> HI=0x40000000, LO=0.
- Move sequence: MTHI 0x12345678 then MFHI -> wdata_o=0x12345678. MTLO leaves HI unchanged.
- Reset mid-multiply: assert rst at BUSY count 10, async and asynchronous to clk -> stallreq_o, HI, LO and wdata_o go to 0 immediately. After release, an OR executes normally with no residual stall.

Source files
------------

// File: rtl/ex_hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_hilo_pkg
//  Description : Opcode/result-select encodings, multiplier FSM states and
//                helpers shared by the execute stage and its multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_hilo_pkg;

    // Result-select bus from decode
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

    // ALU operation bus from decode
    localparam logic [7:0] EXE_NOP_OP    = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP    = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP     = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP    = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP    = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP    = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP    = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP    = 8'b0000_0011;
    localparam logic [7:0] EXE_MFHI_OP   = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP   = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP   = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP   = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP   = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP  = 8'b0001_1001;

    // Iterative multiplier states
    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    // Magnitude of an operand; 0x80000000 maps to 2^31, which fits unsigned 32b
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_hilo_mul.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter
//  Description : Iterative shift-add multiplier, one partial product per
//                cycle. Works on operand magnitudes and applies the sign at
//                the final step so the most negative operand is handled.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_iter
    import ex_hilo_pkg::*;
#(
    parameter int MUL_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_wr,
    output logic [63:0] o_product
);

    localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    mul_state_e  r_state_q, w_state_d;
    logic [CW-1:0] r_cnt_q, w_cnt_d;
    logic [63:0] r_mcand_q, w_mcand_d;
    logic [31:0] r_mplier_q, w_mplier_d;
    logic [63:0] r_acc_q, w_acc_d;
    logic        r_neg_q, w_neg_d;

    logic [63:0] w_step_acc;
    logic        w_last;

    // Accumulator after this cycle's partial product; the final edge uses it directly
    always_comb begin
        w_step_acc = r_acc_q + (r_mplier_q[0] ? r_mcand_q : 64'd0);
        w_last     = (r_state_q == MUL_BUSY) && (r_cnt_q == CW'(MUL_STEPS - 1));
        o_product  = r_neg_q ? (~w_step_acc + 64'd1) : w_step_acc;
        o_busy     = (r_state_q == MUL_BUSY);
        o_done     = (r_state_q == MUL_DONE);
        o_wr       = w_last;
    end

    // Next-state and datapath update for IDLE -> BUSY -> DONE -> IDLE
    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_mcand_d  = r_mcand_q;
        w_mplier_d = r_mplier_q;
        w_acc_d    = r_acc_q;
        w_neg_d    = r_neg_q;
        case (r_state_q)
            MUL_IDLE: begin
                if (i_start) begin
                    w_mcand_d  = {32'd0, mag32(i_a, i_signed)};
                    w_mplier_d = mag32(i_b, i_signed);
                    w_neg_d    = i_signed && (i_a[31] ^ i_b[31]);
                    w_acc_d    = 64'd0;
                    w_cnt_d    = '0;
                    w_state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                w_acc_d    = w_step_acc;
                w_mcand_d  = r_mcand_q << 1;
                w_mplier_d = r_mplier_q >> 1;
                w_cnt_d    = r_cnt_q + CW'(1);
                if (w_last) begin
                    w_state_d = MUL_DONE;
                end
            end
            MUL_DONE: w_state_d = MUL_IDLE;
            default:  w_state_d = MUL_IDLE;
        endcase
    end

    // Multiplier state registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= MUL_IDLE;
            r_cnt_q    <= '0;
            r_mcand_q  <= 64'd0;
            r_mplier_q <= 32'd0;
            r_acc_q    <= 64'd0;
            r_neg_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_mcand_q  <= w_mcand_d;
            r_mplier_q <= w_mplier_d;
            r_acc_q    <= w_acc_d;
            r_neg_q    <= w_neg_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_hilo.sv
`default_nettype none
// ============================================================================
//  Module      : ex_hilo
//  Description : MIPS execute stage with logic/shift/move ops, HI/LO
//                registers and an iterative multiplier that stalls the pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_hilo
    import ex_hilo_pkg::*;
#(
    parameter int MUL_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluOp_i,
    input  logic [2:0]  aluSel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [7:0]  r_op_q,   w_op_d;
    logic [2:0]  r_sel_q,  w_sel_d;
    logic [31:0] r_reg1_q, w_reg1_d;
    logic [31:0] r_reg2_q, w_reg2_d;
    logic [4:0]  r_wd_q,   w_wd_d;
    logic        r_wreg_q, w_wreg_d;
    logic [31:0] r_hi_q,   w_hi_d;
    logic [31:0] r_lo_q,   w_lo_d;

    logic        w_is_mul;
    logic        w_mul_busy;
    logic        w_mul_done;
    logic        w_mul_wr;
    logic [63:0] w_mul_product;
    logic        w_stall;
    logic [31:0] w_result;
    logic [4:0]  w_amt;

    // Stall while a multiply is waiting to start or iterating; DONE releases the latch
    always_comb begin
        w_is_mul = (r_op_q == EXE_MULT_OP) || (r_op_q == EXE_MULTU_OP);
        w_stall  = w_mul_busy || (w_is_mul && !w_mul_done);
    end

    mul_iter #(
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_is_mul),
        .i_signed  (r_op_q == EXE_MULT_OP),
        .i_a       (r_reg1_q),
        .i_b       (r_reg2_q),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_wr      (w_mul_wr),
        .o_product (w_mul_product)
    );

    // Input latch follows decode unless stalled; HI/LO take a product or MTHI/MTLO
    always_comb begin
        w_op_d   = r_op_q;
        w_sel_d  = r_sel_q;
        w_reg1_d = r_reg1_q;
        w_reg2_d = r_reg2_q;
        w_wd_d   = r_wd_q;
        w_wreg_d = r_wreg_q;
        if (!w_stall) begin
            w_op_d   = aluOp_i;
            w_sel_d  = aluSel_i;
            w_reg1_d = reg1_i;
            w_reg2_d = reg2_i;
            w_wd_d   = wd_i;
            w_wreg_d = wreg_i;
        end
        w_hi_d = r_hi_q;
        w_lo_d = r_lo_q;
        // Latch is frozen during BUSY, so a product write never meets MTHI/MTLO
        if (w_mul_wr) begin
            {w_hi_d, w_lo_d} = w_mul_product;
        end else begin
            if (r_op_q == EXE_MTHI_OP) w_hi_d = r_reg1_q;
            if (r_op_q == EXE_MTLO_OP) w_lo_d = r_reg1_q;
        end
    end

    // Latch and HI/LO registers; reset loads a NOP and clears HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_q   <= EXE_NOP_OP;
            r_sel_q  <= EXE_RES_NOP;
            r_reg1_q <= 32'd0;
            r_reg2_q <= 32'd0;
            r_wd_q   <= 5'd0;
            r_wreg_q <= 1'b0;
            r_hi_q   <= 32'd0;
            r_lo_q   <= 32'd0;
        end else begin
            r_op_q   <= w_op_d;
            r_sel_q  <= w_sel_d;
            r_reg1_q <= w_reg1_d;
            r_reg2_q <= w_reg2_d;
            r_wd_q   <= w_wd_d;
            r_wreg_q <= w_wreg_d;
            r_hi_q   <= w_hi_d;
            r_lo_q   <= w_lo_d;
        end
    end

    // Result mux; unknown op/select combinations produce zero
    always_comb begin
        w_result = 32'd0;
        w_amt    = r_reg1_q[4:0];
        case (r_sel_q)
            EXE_RES_LOGIC: begin
                case (r_op_q)
                    EXE_OR_OP:  w_result = r_reg1_q | r_reg2_q;
                    EXE_AND_OP: w_result = r_reg1_q & r_reg2_q;
                    EXE_XOR_OP: w_result = r_reg1_q ^ r_reg2_q;
                    EXE_NOR_OP: w_result = ~(r_reg1_q | r_reg2_q);
                    default:    w_result = 32'd0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (r_op_q)
                    EXE_SLL_OP: w_result = r_reg2_q << w_amt;
                    EXE_SRL_OP: w_result = r_reg2_q >> w_amt;
                    EXE_SRA_OP: w_result = $unsigned($signed(r_reg2_q) >>> w_amt);
                    default:    w_result = 32'd0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (r_op_q)
                    EXE_MFHI_OP: w_result = r_hi_q;
                    EXE_MFLO_OP: w_result = r_lo_q;
                    default:     w_result = 32'd0;
                endcase
            end
            default: w_result = 32'd0;
        endcase
    end

    assign wd_o       = r_wd_q;
    assign wreg_o     = r_wreg_q;
    assign wdata_o    = w_result;
    assign stallreq_o = w_stall;
    assign hi_o       = r_hi_q;
    assign lo_o       = r_lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_hilo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_hilo
//  Description : Self-checking bench for ex_hilo: vector table, hand-written
//                multiply/move/reset sequences and random instruction stream
//                against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_hilo;
    import ex_hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluOp_i  = 8'd0;
    logic [2:0]  aluSel_i = 3'd0;
    logic [31:0] reg1_i   = 32'd0;
    logic [31:0] reg2_i   = 32'd0;
    logic [4:0]  wd_i     = 5'd0;
    logic        wreg_i   = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total = 0;
    int bad   = 0;

    // Architectural model of HI/LO
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    ex_hilo #(.MUL_STEPS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluOp_i    (aluOp_i),
        .aluSel_i   (aluSel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq_o (stallreq_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
        aluOp_i = op; aluSel_i = sel; reg1_i = r1; reg2_i = r2; wd_i = wd; wreg_i = wreg;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction semantics from the ISA description
    function automatic logic [31:0] ref_res(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
        int amt;
        logic signed [31:0] sb;
        amt = int'(a % 32);
        sb  = b;
        if (sel == EXE_RES_LOGIC) begin
            if (op == EXE_OR_OP)  return a | b;
            if (op == EXE_AND_OP) return a & b;
            if (op == EXE_XOR_OP) return a ^ b;
            if (op == EXE_NOR_OP) return ~(a | b);
        end else if (sel == EXE_RES_SHIFT) begin
            if (op == EXE_SLL_OP) return b << amt;
            if (op == EXE_SRL_OP) return b >> amt;
            if (op == EXE_SRA_OP) return $unsigned(sb >>> amt);
        end else if (sel == EXE_RES_MOVE) begin
            if (op == EXE_MFHI_OP) return m_hi;
            if (op == EXE_MFLO_OP) return m_lo;
        end
        return 32'd0;
    endfunction

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x;
        logic [63:0] y;
        x = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        y = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return x * y;
    endfunction

    // Single-cycle instruction: outputs are valid the cycle after capture
    task automatic issue_check(input string nm, input logic [7:0] op, input logic [2:0] sel,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [4:0] wd, input logic wreg);
        drive(op, sel, r1, r2, wd, wreg);
        step();
        chk({nm, " wdata"}, wdata_o, ref_res(op, sel, r1, r2));
        chk({nm, " wd"}, {27'd0, wd_o}, {27'd0, wd});
        chk({nm, " wreg"}, {31'd0, wreg_o}, {31'd0, wreg});
        chk({nm, " stall"}, {31'd0, stallreq_o}, 32'd0);
        chk({nm, " hi"}, hi_o, m_hi);
        chk({nm, " lo"}, lo_o, m_lo);
        if (op == EXE_MTHI_OP) m_hi = r1;
        if (op == EXE_MTLO_OP) m_lo = r1;
    endtask

    // Multiply: count stalled cycles, then check HI/LO in the DONE cycle
    task automatic do_mult(input string nm, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int cnt;
        logic [63:0] p;
        drive(op, EXE_RES_NOP, a, b, 5'd0, 1'b0);
        step();
        cnt = 0;
        while (stallreq_o === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
        chk({nm, " stall cycles"}, 32'(cnt), 32'd33);
        p = ref_mul(op == EXE_MULT_OP, a, b);
        m_hi = p[63:32];
        m_lo = p[31:0];
        chk({nm, " hi"}, hi_o, m_hi);
        chk({nm, " lo"}, lo_o, m_lo);
        chk({nm, " wdata"}, wdata_o, 32'd0);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    logic [7:0] rops[14];
    logic [2:0] rsels[14];

    initial begin
        tbl[0] = '{EXE_OR_OP,  EXE_RES_LOGIC, 32'h0F0F_0000, 32'h0000_FFFF, 5'd3,  1'b1, 32'h0F0F_FFFF};
        tbl[1] = '{EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_0000, 32'h0000_0000, 5'd4,  1'b1, 32'hFFFF_FFFF};
        tbl[2] = '{EXE_SRA_OP, EXE_RES_SHIFT, 32'h0000_0024, 32'h8000_0000, 5'd5,  1'b1, 32'hF800_0000};
        tbl[3] = '{EXE_SRL_OP, EXE_RES_SHIFT, 32'h0000_0024, 32'h8000_0000, 5'd6,  1'b1, 32'h0800_0000};
        tbl[4] = '{EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0020, 32'hA5A5_1234, 5'd7,  1'b1, 32'hA5A5_1234};
        tbl[5] = '{EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8,  1'b0, 32'hF000_F000};
        tbl[6] = '{EXE_XOR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd9,  1'b1, 32'hF0F0_0F0F};
        tbl[7] = '{EXE_OR_OP,  EXE_RES_NOP,   32'h1234_5678, 32'h8765_4321, 5'd10, 1'b1, 32'h0000_0000};
        tbl[8] = '{8'hFF,      EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'h1111_1111, 5'd31, 1'b1, 32'h0000_0000};
        tbl[9] = '{EXE_SLL_OP, EXE_RES_SHIFT, 32'hFFFF_FFE4, 32'h0000_000F, 5'd1,  1'b1, 32'h0000_00F0};

        rops  = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
                  EXE_MFHI_OP, EXE_MFLO_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_NOP_OP, EXE_MULT_OP, EXE_MULTU_OP};
        rsels = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_SHIFT,
                  EXE_RES_SHIFT, EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_NOP,
                  EXE_RES_NOP, EXE_RES_NOP};

        // Reset state, with live inputs that must not be captured
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'h1, 5'd7, 1'b1);
        #12;
        chk("reset wdata", wdata_o, 32'd0);
        chk("reset wd", {27'd0, wd_o}, 32'd0);
        chk("reset wreg", {31'd0, wreg_o}, 32'd0);
        chk("reset stall", {31'd0, stallreq_o}, 32'd0);
        chk("reset hi", hi_o, 32'd0);
        chk("reset lo", lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].op, tbl[i].sel, tbl[i].r1, tbl[i].r2, tbl[i].wd, tbl[i].wreg);
            step();
            chk($sformatf("vec%0d wdata", i), wdata_o, tbl[i].exp);
            chk($sformatf("vec%0d wd", i), {27'd0, wd_o}, {27'd0, tbl[i].wd});
            chk($sformatf("vec%0d wreg", i), {31'd0, wreg_o}, {31'd0, tbl[i].wreg});
        end

        // Signed multiply followed by MFLO
        do_mult("mult -2x3", EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3);
        chk("mult -2x3 hi const", hi_o, 32'hFFFF_FFFF);
        chk("mult -2x3 lo const", lo_o, 32'hFFFF_FFFA);
        issue_check("mflo after mult", EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
        chk("mflo const", wdata_o, 32'hFFFF_FFFA);

        // Unsigned max squared, then back-to-back signed most-negative squared
        do_mult("multu max", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu hi const", hi_o, 32'hFFFF_FFFE);
        chk("multu lo const", lo_o, 32'h0000_0001);
        do_mult("mult minneg", EXE_MULT_OP, 32'h8000_0000, 32'h8000_0000);
        chk("minneg hi const", hi_o, 32'h4000_0000);
        chk("minneg lo const", lo_o, 32'h0000_0000);

        // Move sequence
        issue_check("mthi", EXE_MTHI_OP, EXE_RES_MOVE, 32'h1234_5678, 32'd0, 5'd0, 1'b0);
        issue_check("mfhi", EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd9, 1'b1);
        chk("mfhi const", wdata_o, 32'h1234_5678);
        issue_check("mtlo", EXE_MTLO_OP, EXE_RES_MOVE, 32'hCAFE_BABE, 32'd0, 5'd0, 1'b0);
        issue_check("mflo", EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd9, 1'b1);
        chk("mflo new const", wdata_o, 32'hCAFE_BABE);
        chk("mtlo keeps hi", hi_o, 32'h1234_5678);

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            int k;
            k = $urandom_range(0, 13);
            if (rops[k] == EXE_MULT_OP || rops[k] == EXE_MULTU_OP)
                do_mult($sformatf("rnd%0d mul", n), rops[k], rnd32(), rnd32());
            else
                issue_check($sformatf("rnd%0d", n), rops[k], rsels[k], rnd32(), rnd32(),
                            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a multiply, off the clock edge
        issue_check("pre-rst mthi", EXE_MTHI_OP, EXE_RES_MOVE, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b0);
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'h0000_1234, 32'h0000_5678, 5'd0, 1'b0);
        step();
        repeat (11) @(posedge clk);
        #3;
        chk("mid-mul stall before rst", {31'd0, stallreq_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst stall", {31'd0, stallreq_o}, 32'd0);
        chk("rst hi", hi_o, 32'd0);
        chk("rst lo", lo_o, 32'd0);
        chk("rst wdata", wdata_o, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_00F0, 32'h0000_000F, 5'd12, 1'b1);
        #2;
        rst = 1'b0;
        issue_check("post-rst or", EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_00F0, 32'h0000_000F, 5'd12, 1'b1);
        chk("post-rst or const", wdata_o, 32'h0000_00FF);
        issue_check("post-rst nop", EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
